shared_mem_dma_master: RTL and testbench



---
 rtl/shared_mem_pkg.sv | 26 ++
 rtl/shared_mem_dma_master_addr_gen.sv | 44 ++++
 rtl/shared_mem_dma_master.sv | 148 ++++++++++++++
 tb/tb_shared_mem_dma_master.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/shared_mem_pkg.sv
// Shared types and sizes for the shared-RAM block-command DMA master.
package shared_mem_pkg;

  localparam int ADDR_W = 14;
  localparam int DATA_W = 32;
  localparam int LEN_W  = 15;
  localparam int BE_W   = DATA_W / 8;

  typedef enum logic [1:0] {
    OP_FILL = 2'd0,
    OP_COPY = 2'd1,
    OP_SUM  = 2'd2,
    OP_NOP  = 2'd3
  } op_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FILL,
    S_CP_RD,
    S_CP_WR,
    S_SUM,
    S_DRAIN,
    S_DONE
  } state_e;

endpackage

// File: rtl/shared_mem_dma_master_addr_gen.sv
// Word index counter with latched bases; produces wrapped src/dst
// addresses and a flag marking the final word of the block.
module shared_mem_addr_gen
  import shared_mem_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              step,
  input  logic [ADDR_W-1:0] src,
  input  logic [ADDR_W-1:0] dst,
  input  logic [LEN_W-1:0]  len,
  output logic [LEN_W-1:0]  idx,
  output logic [ADDR_W-1:0] src_addr,
  output logic [ADDR_W-1:0] dst_addr,
  output logic              last
);

  logic [ADDR_W-1:0] src_q;
  logic [ADDR_W-1:0] dst_q;
  logic [LEN_W-1:0]  len_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      src_q <= '0;
      dst_q <= '0;
      len_q <= '0;
      idx   <= '0;
    end else if (load) begin
      src_q <= src;
      dst_q <= dst;
      len_q <= len;
      idx   <= '0;
    end else if (step) begin
      idx   <= idx + 1'b1;
    end
  end

  // Truncation to ADDR_W gives the modulo-2^14 wrap.
  assign src_addr = src_q + idx[ADDR_W-1:0];
  assign dst_addr = dst_q + idx[ADDR_W-1:0];
  assign last     = (idx == len_q - 1'b1);

endmodule

// File: rtl/shared_mem_dma_master.sv
// Block-command (fill/copy/checksum) Avalon-MM master for the
// single-port shared RAM with read latency 1 and gated clock enable.
module shared_mem_dma_master
  import shared_mem_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [ADDR_W-1:0] cmd_src,
  input  logic [ADDR_W-1:0] cmd_dst,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic [DATA_W-1:0] cmd_data,
  input  logic              pause,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] result,
  output logic [ADDR_W-1:0] avm_address,
  output logic [BE_W-1:0]   avm_byteenable,
  output logic              avm_chipselect,
  output logic              avm_write,
  output logic [DATA_W-1:0] avm_writedata,
  output logic              avm_clken,
  output logic              avm_reset_req,
  input  logic [DATA_W-1:0] avm_readdata
);

  state_e            state;
  state_e            state_n;
  op_e               op;
  logic              accept;
  logic              step;
  logic              acc_en;
  logic              active;
  logic              bus;
  logic              rd_src;
  logic              last;
  logic [LEN_W-1:0]  idx;
  logic [ADDR_W-1:0] src_addr;
  logic [ADDR_W-1:0] dst_addr;
  logic [DATA_W-1:0] data_q;
  logic [DATA_W-1:0] acc_q;

  assign op     = op_e'(cmd_op);
  assign accept = cmd_valid & cmd_ready;

  shared_mem_addr_gen u_addr_gen (
    .clk      (clk),
    .reset    (reset),
    .load     (accept),
    .step     (step),
    .src      (cmd_src),
    .dst      (cmd_dst),
    .len      (cmd_len),
    .idx      (idx),
    .src_addr (src_addr),
    .dst_addr (dst_addr),
    .last     (last)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_n;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      data_q <= '0;
      acc_q  <= '0;
    end else if (accept) begin
      data_q <= cmd_data;
      acc_q  <= '0;
    end else if (acc_en) begin
      acc_q  <= acc_q + avm_readdata;
    end
  end

  always_comb begin
    state_n = state;
    step    = 1'b0;
    acc_en  = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (accept) begin
          if (cmd_len == '0) state_n = S_DONE;
          else begin
            unique case (op)
              OP_FILL: state_n = S_FILL;
              OP_COPY: state_n = S_CP_RD;
              OP_SUM:  state_n = S_SUM;
              default: state_n = S_DONE;
            endcase
          end
        end
      end
      S_FILL: if (!pause) begin
        step = 1'b1;
        if (last) state_n = S_DONE;
      end
      S_CP_RD: if (!pause) state_n = S_CP_WR;
      S_CP_WR: if (!pause) begin
        step    = 1'b1;
        state_n = last ? S_DONE : S_CP_RD;
      end
      // The first SUM cycle has no earlier read to accumulate.
      S_SUM: if (!pause) begin
        step   = 1'b1;
        acc_en = (idx != '0);
        if (last) state_n = S_DRAIN;
      end
      S_DRAIN: if (!pause) begin
        acc_en  = 1'b1;
        state_n = S_DONE;
      end
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  assign active = state inside {S_FILL, S_CP_RD, S_CP_WR, S_SUM};
  assign rd_src = state inside {S_CP_RD, S_SUM};
  assign bus    = active & ~pause & ~reset;

  assign cmd_ready = (state == S_IDLE);
  assign busy      = ~cmd_ready;
  assign done      = (state == S_DONE);
  assign result    = acc_q;

  assign avm_chipselect = bus;
  assign avm_write      = bus & (state inside {S_FILL, S_CP_WR});
  assign avm_address    = bus ? (rd_src ? src_addr : dst_addr) : '0;
  assign avm_byteenable = '1;
  assign avm_reset_req  = reset;
  // Gating the RAM clock freezes a pending readdata across a pause.
  assign avm_clken      = ~(pause & (active | (state == S_DRAIN)));

  always_comb begin
    avm_writedata = '0;
    if (avm_write) begin
      if (state == S_FILL)
        avm_writedata = data_q + {{(DATA_W-LEN_W){1'b0}}, idx};
      else
        avm_writedata = avm_readdata;
    end
  end

endmodule

// File: tb/tb_shared_mem_dma_master.sv
// Scoreboard bench for shared_mem_dma_master against a latency-1
// RAM model with clock-enable.
module tb_shared_mem_dma_master;
  import shared_mem_pkg::*;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              cmd_valid = 1'b0;
  logic              cmd_ready;
  logic [1:0]        cmd_op = '0;
  logic [ADDR_W-1:0] cmd_src = '0;
  logic [ADDR_W-1:0] cmd_dst = '0;
  logic [LEN_W-1:0]  cmd_len = '0;
  logic [DATA_W-1:0] cmd_data = '0;
  logic              pause = 1'b0;
  logic              busy;
  logic              done;
  logic [DATA_W-1:0] result;
  logic [ADDR_W-1:0] avm_address;
  logic [BE_W-1:0]   avm_byteenable;
  logic              avm_chipselect;
  logic              avm_write;
  logic [DATA_W-1:0] avm_writedata;
  logic              avm_clken;
  logic              avm_reset_req;
  logic [DATA_W-1:0] avm_readdata;

  always #5 clk = ~clk;

  shared_mem_dma_master dut (
    .clk            (clk),
    .reset          (reset),
    .cmd_valid      (cmd_valid),
    .cmd_ready      (cmd_ready),
    .cmd_op         (cmd_op),
    .cmd_src        (cmd_src),
    .cmd_dst        (cmd_dst),
    .cmd_len        (cmd_len),
    .cmd_data       (cmd_data),
    .pause          (pause),
    .busy           (busy),
    .done           (done),
    .result         (result),
    .avm_address    (avm_address),
    .avm_byteenable (avm_byteenable),
    .avm_chipselect (avm_chipselect),
    .avm_write      (avm_write),
    .avm_writedata  (avm_writedata),
    .avm_clken      (avm_clken),
    .avm_reset_req  (avm_reset_req),
    .avm_readdata   (avm_readdata)
  );

  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
  logic [DATA_W-1:0] rdata_q = '0;
  int nrd = 0;
  int nwr = 0;

  assign avm_readdata = rdata_q;

  always @(posedge clk) begin
    if (avm_clken && avm_chipselect) begin
      if (avm_write) begin
        mem[avm_address] <= avm_writedata;
        nwr <= nwr + 1;
      end else begin
        rdata_q <= mem[avm_address];
        nrd <= nrd + 1;
      end
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  typedef struct {
    string       tag;
    int          cyc;
    logic [31:0] res;
    int          rd;
    int          wr;
  } exp_t;

  exp_t sb[$];

  function automatic logic [31:0] model_sum(input logic [13:0] s,
                                            input logic [14:0] n);
    logic [31:0] a;
    logic [13:0] ad;
    a = '0;
    for (int k = 0; k < int'(n); k++) begin
      ad = s + 14'(k);
      a  = a + mem[ad];
    end
    return a;
  endfunction

  task automatic run(input string tag, input logic [1:0] op,
                     input logic [13:0] src, input logic [13:0] dst,
                     input logic [14:0] len, input logic [31:0] data,
                     input int ecyc, input int erd, input int ewr,
                     input int ps, input int pl, input bit hold);
    exp_t e;
    exp_t x;
    int c;
    int dcyc;
    int rd0;
    int wr0;
    e.tag = tag;
    e.cyc = ecyc;
    e.res = (op == 2'd2) ? model_sum(src, len) : 32'h0;
    e.rd  = erd;
    e.wr  = ewr;
    sb.push_back(e);
    @(posedge clk);
    #1;
    cmd_op = op; cmd_src = src; cmd_dst = dst;
    cmd_len = len; cmd_data = data; cmd_valid = 1'b1;
    #1;
    chk({tag, "_ready"}, 32'(cmd_ready), 32'd1);
    @(posedge clk);
    #1;
    rd0 = nrd;
    wr0 = nwr;
    dcyc = -1;
    c = 1;
    while (dcyc < 0 && c < 20000) begin
      cmd_valid = hold;
      pause = (c >= ps) && (c < ps + pl);
      #1;
      if (pause) begin
        chk({tag, "_pause_clken"}, 32'(avm_clken), 32'd0);
        chk({tag, "_pause_cs"}, 32'(avm_chipselect), 32'd0);
      end
      if (done) dcyc = c;
      else begin
        @(posedge clk);
        #1;
        c++;
      end
    end
    pause = 1'b0;
    x = sb.pop_front();
    chk({x.tag, "_done_cyc"}, 32'(dcyc), 32'(x.cyc));
    chk({x.tag, "_result"}, result, x.res);
    chk({x.tag, "_busy_at_done"}, 32'(busy), 32'd1);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    chk({x.tag, "_done_pulse"}, 32'(done), 32'd0);
    chk({x.tag, "_idle_busy"}, 32'(busy), 32'd0);
    chk({x.tag, "_idle_ready"}, 32'(cmd_ready), 32'd1);
    chk({x.tag, "_reads"}, 32'(nrd - rd0), 32'(x.rd));
    chk({x.tag, "_writes"}, 32'(nwr - wr0), 32'(x.wr));
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ready"}, 32'(cmd_ready), 32'd1);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_result"}, result, 32'd0);
    chk({tag, "_addr"}, 32'(avm_address), 32'd0);
    chk({tag, "_cs"}, 32'(avm_chipselect), 32'd0);
    chk({tag, "_wr"}, 32'(avm_write), 32'd0);
    chk({tag, "_wdata"}, avm_writedata, 32'd0);
    chk({tag, "_clken"}, 32'(avm_clken), 32'd1);
    chk({tag, "_be"}, 32'(avm_byteenable), 32'hF);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int k = 0; k < (1 << ADDR_W); k++) mem[k] = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req_high", 32'(avm_reset_req), 32'd1);
    reset = 1'b0;
    #1;
    chk_reset_outputs("por");
    chk("rst_req_low", 32'(avm_reset_req), 32'd0);

    run("fill4", 2'd0, 14'h0, 14'h0010, 15'd4, 32'hA000_0000,
        5, 0, 4, 0, 0, 1'b0);
    for (int k = 0; k < 4; k++)
      chk($sformatf("fill4_m%0d", k), mem[14'h10 + k], 32'hA000_0000 + k);
    chk("fill4_m4", mem[14'h14], 32'h0);

    mem[0] = 32'd1; mem[1] = 32'd2; mem[2] = 32'd3;
    run("copy3", 2'd1, 14'h0, 14'h0100, 15'd3, 32'h0,
        7, 3, 3, 0, 0, 1'b0);
    for (int k = 0; k < 3; k++)
      chk($sformatf("copy3_m%0d", k), mem[14'h100 + k], 32'(k + 1));

    mem[0] = 32'd5; mem[1] = 32'd7;
    mem[14'h3FFE] = 32'hFFFF_FFFF; mem[14'h3FFF] = 32'd1;
    run("sum4", 2'd2, 14'h3FFE, 14'h0, 15'd4, 32'h0,
        6, 4, 0, 0, 0, 1'b0);
    chk("sum4_const", result, 32'h0000_000C);

    run("sum3", 2'd2, 14'h3FFE, 14'h0, 15'd3, 32'h0,
        5, 3, 0, 0, 0, 1'b0);
    run("sum3_pause", 2'd2, 14'h3FFE, 14'h0, 15'd3, 32'h0,
        7, 3, 0, 2, 2, 1'b0);
    chk("sum3_pause_const", result, 32'h0000_0005);

    run("fill_len0", 2'd0, 14'h0, 14'h0200, 15'd0, 32'h1234,
        1, 0, 0, 0, 0, 1'b1);
    run("nop", 2'd3, 14'h0, 14'h0200, 15'd5, 32'h1234,
        1, 0, 0, 0, 0, 1'b1);
    chk("len0_mem", mem[14'h200], 32'h0);

    run("fill_wrap", 2'd0, 14'h0, 14'h3FFE, 15'd3, 32'hFFFF_FFFF,
        4, 0, 3, 0, 0, 1'b0);
    chk("fill_wrap_m0", mem[14'h3FFE], 32'hFFFF_FFFF);
    chk("fill_wrap_m1", mem[14'h3FFF], 32'h0);
    chk("fill_wrap_m2", mem[14'h0000], 32'h1);

    for (int k = 0; k < 6; k++) begin
      mem[k] = 32'h11 * (k + 1);
      mem[14'h300 + k] = '0;
    end
    @(posedge clk);
    #1;
    cmd_op = 2'd1; cmd_src = 14'h0; cmd_dst = 14'h300;
    cmd_len = 15'd6; cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    chk("midrst_req", 32'(avm_reset_req), 32'd1);
    chk("midrst_cs", 32'(avm_chipselect), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    chk_reset_outputs("midrst");
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      chk($sformatf("midrst_nodone%0d", k), 32'(done), 32'd0);
      chk($sformatf("midrst_nocs%0d", k), 32'(avm_chipselect), 32'd0);
    end
    chk("midrst_m0", mem[14'h300], 32'h11);
    chk("midrst_m1", mem[14'h301], 32'h22);
    for (int k = 2; k < 6; k++)
      chk($sformatf("midrst_m%0d", k), mem[14'h300 + k], 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
